// File: rtl/ram_true_dp_sc_init_if.sv
// One RAM access port: request fields from the engine, registered read data back.
// en is a single-cycle request with no backpressure; every enabled cycle is accepted, and vld pulses once with dout.
interface ram_true_dp_sc_init_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 15,
    parameter int LANE_W = 4
);
    localparam int NUM_LANES = DATA_W / LANE_W;

    logic                 en;
    logic                 we;
    logic [NUM_LANES-1:0] be;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    din;
    logic [DATA_W-1:0]    dout;
    logic                 vld;

    modport master (
        output en, we, be, addr, din,
        input  dout, vld
    );

    modport slave (
        input  en, we, be, addr, din,
        output dout, vld
    );
endinterface

// File: rtl/ram_true_dp_sc_init.sv
// Single-clock true dual-port RAM with lane enables, post-reset init sweep and collision counting.
// Optional macro RAM_OUT_REG_EN adds a second output register stage per port (read latency 2).
module ram_true_dp_sc_init #(
    parameter int               DATA_W   = 4,
    parameter int               ADDR_W   = 15,
    parameter int               LANE_W   = 4,
    parameter int               RDW_MODE = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_busy,
    ram_true_dp_sc_init_if.slave port_a,
    ram_true_dp_sc_init_if.slave port_b,
    output logic                 coll,
    output logic [15:0]          coll_cnt,
    output logic [1:0]           dbg_state
);
    localparam int NUM_LANES  = DATA_W / LANE_W;
    localparam int DEPTH      = 2 ** ADDR_W;
    localparam bit WRITE_THRU = (RDW_MODE != 0);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic              sweep_we;
    logic              sweep_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              acc_a;
    logic              acc_b;
    logic              rd_a;
    logic              rd_b;
    logic              wr_a;
    logic              wr_b;
    logic              same_addr;
    logic              coll_nxt;
    logic [DATA_W-1:0] old_a;
    logic [DATA_W-1:0] old_b;
    logic [DATA_W-1:0] new_a;
    logic [DATA_W-1:0] new_b;

    logic [DATA_W-1:0] dout1_a;
    logic [DATA_W-1:0] dout1_b;
    logic              vld1_a;
    logic              vld1_b;

    // ---------------------------------------------------------------
    // Init sweep FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sweep_we  = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_we = 1'b1;
                ptr_nxt  = ptr + 1'b1;
                if (ptr == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign init_busy = (state != ST_READY);
    assign dbg_state = state;
    assign ready     = (state == ST_READY);
    assign sweep_wr  = rst_n && sweep_we;

    // ---------------------------------------------------------------
    // Access qualification and collision detection
    // ---------------------------------------------------------------
    assign acc_a     = rst_n && ready && port_a.en;
    assign acc_b     = rst_n && ready && port_b.en;
    assign rd_a      = acc_a && !port_a.we;
    assign rd_b      = acc_b && !port_b.we;
    assign wr_a      = acc_a && port_a.we;
    assign wr_b      = acc_b && port_b.we;
    assign same_addr = (port_a.addr == port_b.addr);
    assign coll_nxt  = acc_a && acc_b && same_addr && (port_a.we || port_b.we);

    // Both merged words describe the final content of their address, so a
    // same-address write/write pair yields identical words with port A winning per lane.
    always_comb begin
        old_a = mem[port_a.addr];
        old_b = mem[port_b.addr];
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (port_a.be[i]) begin
                new_a[i*LANE_W +: LANE_W] = port_a.din[i*LANE_W +: LANE_W];
            end else if (same_addr && wr_b && port_b.be[i]) begin
                new_a[i*LANE_W +: LANE_W] = port_b.din[i*LANE_W +: LANE_W];
            end
            if (same_addr && wr_a && port_a.be[i]) begin
                new_b[i*LANE_W +: LANE_W] = port_a.din[i*LANE_W +: LANE_W];
            end else if (port_b.be[i]) begin
                new_b[i*LANE_W +: LANE_W] = port_b.din[i*LANE_W +: LANE_W];
            end
        end
    end

    // ---------------------------------------------------------------
    // Storage (not reset; the sweep provides the known contents)
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            mem[ptr] <= INIT_VAL;
        end else begin
            if (wr_a) begin
                mem[port_a.addr] <= new_a;
            end
            if (wr_b && !(wr_a && same_addr)) begin
                mem[port_b.addr] <= new_b;
            end
        end
    end

    // ---------------------------------------------------------------
    // First output stage: reads are read-first, writes follow RDW_MODE
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout1_a <= '0;
            dout1_b <= '0;
            vld1_a  <= 1'b0;
            vld1_b  <= 1'b0;
        end else begin
            vld1_a <= rd_a || (wr_a && WRITE_THRU);
            vld1_b <= rd_b || (wr_b && WRITE_THRU);
            if (rd_a) begin
                dout1_a <= old_a;
            end else if (wr_a && WRITE_THRU) begin
                dout1_a <= new_a;
            end
            if (rd_b) begin
                dout1_b <= old_b;
            end else if (wr_b && WRITE_THRU) begin
                dout1_b <= new_b;
            end
        end
    end

    // ---------------------------------------------------------------
    // Collision pulse and saturating counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= coll_nxt;
            if (coll_nxt && (coll_cnt != 16'hFFFF)) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_W-1:0] dout2_a;
    logic [DATA_W-1:0] dout2_b;
    logic              vld2_a;
    logic              vld2_b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout2_a <= '0;
            dout2_b <= '0;
            vld2_a  <= 1'b0;
            vld2_b  <= 1'b0;
        end else begin
            dout2_a <= dout1_a;
            dout2_b <= dout1_b;
            vld2_a  <= vld1_a;
            vld2_b  <= vld1_b;
        end
    end

    assign port_a.dout = dout2_a;
    assign port_a.vld  = vld2_a;
    assign port_b.dout = dout2_b;
    assign port_b.vld  = vld2_b;
`else
    assign port_a.dout = dout1_a;
    assign port_a.vld  = vld1_a;
    assign port_b.dout = dout1_b;
    assign port_b.vld  = vld1_b;
`endif

endmodule

// File: tb/tb_ram_true_dp_sc_init.sv
// Bench for ram_true_dp_sc_init: one no-change and one write-through instance share stimulus, checked against a word-level model.
module tb_ram_true_dp_sc_init;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       en_a, we_a, en_b, we_b;
    logic [1:0] be_a, be_b;
    logic [3:0] addr_a, addr_b;
    logic [7:0] din_a, din_b;

    logic        busy0, busy1, coll0, coll1;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  dbg0, dbg1;

    logic        act_busy [2];
    logic        act_coll [2];
    logic [15:0] act_cnt  [2];
    logic        act_vld  [2][2];
    logic [7:0]  act_dout [2][2];

    int n_checks;
    int n_fail;

    // Model state
    logic [7:0]  m_mem [16];
    bit          m_busy;
    int          m_sweep;
    bit          m_coll;
    logic [15:0] m_cnt;
    logic [7:0]  s1_dout [2][2];
    logic [7:0]  s2_dout [2][2];
    bit          s1_vld  [2][2];
    bit          s2_vld  [2][2];

    ram_true_dp_sc_init_if #(.DATA_W(8), .ADDR_W(4), .LANE_W(4)) if_a0 ();
    ram_true_dp_sc_init_if #(.DATA_W(8), .ADDR_W(4), .LANE_W(4)) if_b0 ();
    ram_true_dp_sc_init_if #(.DATA_W(8), .ADDR_W(4), .LANE_W(4)) if_a1 ();
    ram_true_dp_sc_init_if #(.DATA_W(8), .ADDR_W(4), .LANE_W(4)) if_b1 ();

    assign if_a0.en = en_a;   assign if_a1.en = en_a;
    assign if_a0.we = we_a;   assign if_a1.we = we_a;
    assign if_a0.be = be_a;   assign if_a1.be = be_a;
    assign if_a0.addr = addr_a; assign if_a1.addr = addr_a;
    assign if_a0.din = din_a; assign if_a1.din = din_a;
    assign if_b0.en = en_b;   assign if_b1.en = en_b;
    assign if_b0.we = we_b;   assign if_b1.we = we_b;
    assign if_b0.be = be_b;   assign if_b1.be = be_b;
    assign if_b0.addr = addr_b; assign if_b1.addr = addr_b;
    assign if_b0.din = din_b; assign if_b1.din = din_b;

    ram_true_dp_sc_init #(
        .DATA_W(8), .ADDR_W(4), .LANE_W(4), .RDW_MODE(0), .INIT_VAL(8'hA5)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .port_a(if_a0), .port_b(if_b0),
        .coll(coll0), .coll_cnt(cnt0), .dbg_state(dbg0)
    );

    ram_true_dp_sc_init #(
        .DATA_W(8), .ADDR_W(4), .LANE_W(4), .RDW_MODE(1), .INIT_VAL(8'hA5)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .port_a(if_a1), .port_b(if_b1),
        .coll(coll1), .coll_cnt(cnt1), .dbg_state(dbg1)
    );

    assign act_busy[0] = busy0;  assign act_busy[1] = busy1;
    assign act_coll[0] = coll0;  assign act_coll[1] = coll1;
    assign act_cnt[0]  = cnt0;   assign act_cnt[1]  = cnt1;
    assign act_vld[0][0]  = if_a0.vld;  assign act_vld[0][1]  = if_b0.vld;
    assign act_vld[1][0]  = if_a1.vld;  assign act_vld[1][1]  = if_b1.vld;
    assign act_dout[0][0] = if_a0.dout; assign act_dout[0][1] = if_b0.dout;
    assign act_dout[1][0] = if_a1.dout; assign act_dout[1][1] = if_b1.dout;

    // ---------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------
    // Reference model: one call per rising edge, from the inputs seen there
    // ---------------------------------------------------------------
    function automatic void model_edge();
        logic [7:0] nm [16];
        bit         rda, rdb, wra, wrb;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    s1_dout[d][p] = 8'h00; s2_dout[d][p] = 8'h00;
                    s1_vld[d][p]  = 1'b0;  s2_vld[d][p]  = 1'b0;
                end
            end
            m_busy = 1'b1; m_sweep = 0; m_coll = 1'b0; m_cnt = 16'h0;
            return;
        end
        s2_dout = s1_dout;
        s2_vld  = s1_vld;
        if (m_busy) begin
            m_sweep++;
            m_coll = 1'b0;
            for (int d = 0; d < 2; d++) begin
                s1_vld[d][0] = 1'b0; s1_vld[d][1] = 1'b0;
            end
            if (m_sweep == 16) begin
                m_busy = 1'b0;
                for (int i = 0; i < 16; i++) m_mem[i] = 8'hA5;
            end
            return;
        end
        rda = en_a && !we_a; wra = en_a && we_a;
        rdb = en_b && !we_b; wrb = en_b && we_b;
        nm = m_mem;
        // B first, then A on top: A wins any lane both enable
        if (wrb) for (int i = 0; i < 2; i++) if (be_b[i]) nm[addr_b][i*4 +: 4] = din_b[i*4 +: 4];
        if (wra) for (int i = 0; i < 2; i++) if (be_a[i]) nm[addr_a][i*4 +: 4] = din_a[i*4 +: 4];
        for (int d = 0; d < 2; d++) begin
            s1_vld[d][0] = rda || (wra && d == 1);
            if (rda) s1_dout[d][0] = m_mem[addr_a];
            else if (wra && d == 1) s1_dout[d][0] = nm[addr_a];
            s1_vld[d][1] = rdb || (wrb && d == 1);
            if (rdb) s1_dout[d][1] = m_mem[addr_b];
            else if (wrb && d == 1) s1_dout[d][1] = nm[addr_b];
        end
        m_coll = en_a && en_b && (addr_a == addr_b) && (we_a || we_b);
        if (m_coll && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_mem = nm;
    endfunction

    function automatic logic [7:0] e_dout(int d, int p);
        return (LAT == 2) ? s2_dout[d][p] : s1_dout[d][p];
    endfunction

    function automatic bit e_vld(int d, int p);
        return (LAT == 2) ? s2_vld[d][p] : s1_vld[d][p];
    endfunction

    // ---------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = 4'd0; din_a = 8'h00;
        en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = 4'd0; din_b = 8'h00;
    endtask

    task automatic drive_a(input logic en, input logic we, input logic [1:0] be,
                           input logic [3:0] addr, input logic [7:0] din);
        en_a = en; we_a = we; be_a = be; addr_a = addr; din_a = din;
    endtask

    task automatic drive_b(input logic en, input logic we, input logic [1:0] be,
                           input logic [3:0] addr, input logic [7:0] din);
        en_b = en; we_b = we; be_b = be; addr_b = addr; din_b = din;
    endtask

    task automatic wait_lat();
        for (int k = 1; k < LAT; k++) step();
    endtask

    // ---------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------
    task automatic test_reset();
        int n;
        idle();
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_busy[d] !== 1'b1) begin n_fail++; $display("FAIL reset_busy d%0d got %0b exp 1", d, act_busy[d]); end
            n_checks++;
            if (act_coll[d] !== 1'b0) begin n_fail++; $display("FAIL reset_coll d%0d got %0b exp 0", d, act_coll[d]); end
            n_checks++;
            if (act_cnt[d] !== 16'h0) begin n_fail++; $display("FAIL reset_cnt d%0d got %h exp 0000", d, act_cnt[d]); end
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (act_vld[d][p] !== 1'b0 || act_dout[d][p] !== 8'h00) begin
                    n_fail++;
                    $display("FAIL reset_dout d%0d p%0d got vld=%0b dout=%h exp vld=0 dout=00", d, p, act_vld[d][p], act_dout[d][p]);
                end
            end
        end
        rst_n = 1'b1;
        n = 0;
        while (act_busy[0] && n < 40) begin step(); n++; end
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL init_len got %0d cycles exp 16", n); end
        n_checks++;
        if (act_busy[1] !== 1'b0 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL init_done d1 got %0b exp 0", act_busy[1]);
        end
    endtask

    task automatic test_init_readback();
        for (int i = 0; i < 16 + LAT; i++) begin
            if (i < 16) begin
                drive_a(1'b1, 1'b0, 2'b00, 4'(i), 8'h00);
                drive_b(1'b1, 1'b0, 2'b00, 4'(15 - i), 8'h00);
            end else begin
                idle();
            end
            step();
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    n_checks++;
                    if (act_vld[d][p] !== e_vld(d, p)) begin
                        n_fail++; $display("FAIL init_rd_vld d%0d p%0d i%0d got %0b exp %0b", d, p, i, act_vld[d][p], e_vld(d, p));
                    end
                    n_checks++;
                    if (act_dout[d][p] !== e_dout(d, p)) begin
                        n_fail++; $display("FAIL init_rd_dout d%0d p%0d i%0d got %h exp %h", d, p, i, act_dout[d][p], e_dout(d, p));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive_a(1'b1, 1'b1, 2'b11, 4'd9, 8'h3C);
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n = 0;
        while (act_busy[0] && n < 40) begin step(); n++; end
        idle();
        n_checks++;
        if (n != 16) begin n_fail++; $display("FAIL restart_len got %0d cycles exp 16", n); end
        drive_a(1'b1, 1'b0, 2'b00, 4'd9, 8'h00);
        step();
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vld[d][0] !== 1'b1 || act_dout[d][0] !== 8'hA5) begin
                n_fail++; $display("FAIL sweep_ignores_wr d%0d got vld=%0b dout=%h exp vld=1 dout=a5", d, act_vld[d][0], act_dout[d][0]);
            end
        end
    endtask

    task automatic test_lane_mask();
        drive_a(1'b1, 1'b1, 2'b11, 4'd3, 8'h12);
        step();
        drive_a(1'b1, 1'b1, 2'b01, 4'd3, 8'hFF);
        step();
        drive_a(1'b1, 1'b0, 2'b00, 4'd3, 8'h00);
        step();
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_vld[d][0] !== 1'b1 || act_dout[d][0] !== 8'h1F) begin
                n_fail++; $display("FAIL lane_mask d%0d got vld=%0b dout=%h exp vld=1 dout=1f", d, act_vld[d][0], act_dout[d][0]);
            end
        end
    endtask

    task automatic test_write_write_coll();
        logic        got_coll [2];
        logic [15:0] got_cnt  [2];
        drive_a(1'b1, 1'b1, 2'b11, 4'd5, 8'h00);
        step();
        drive_a(1'b1, 1'b1, 2'b10, 4'd5, 8'hAA);
        drive_b(1'b1, 1'b1, 2'b11, 4'd5, 8'h55);
        step();
        got_coll = act_coll;
        got_cnt  = act_cnt;
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_coll[d] !== 1'b1 || got_cnt[d] !== 16'd1) begin
                n_fail++; $display("FAIL ww_coll d%0d got coll=%0b cnt=%0d exp coll=1 cnt=1", d, got_coll[d], got_cnt[d]);
            end
        end
        n_checks++;
        if (act_vld[1][0] !== 1'b1 || act_dout[1][0] !== 8'hA5 || act_vld[1][1] !== 1'b1 || act_dout[1][1] !== 8'hA5) begin
            n_fail++; $display("FAIL ww_thru got a=%h/%0b b=%h/%0b exp a5/1 a5/1", act_dout[1][0], act_vld[1][0], act_dout[1][1], act_vld[1][1]);
        end
        n_checks++;
        if (act_vld[0][0] !== 1'b0 || act_vld[0][1] !== 1'b0) begin
            n_fail++; $display("FAIL ww_nochg_vld got a=%0b b=%0b exp 0 0", act_vld[0][0], act_vld[0][1]);
        end
        drive_b(1'b1, 1'b0, 2'b00, 4'd5, 8'h00);
        step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_coll[d] !== 1'b0) begin n_fail++; $display("FAIL ww_coll_pulse d%0d got %0b exp 0", d, act_coll[d]); end
        end
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_dout[d][1] !== 8'hA5) begin n_fail++; $display("FAIL ww_mem d%0d got %h exp a5", d, act_dout[d][1]); end
        end
    endtask

    task automatic test_read_write_coll();
        logic        got_coll [2];
        logic [15:0] got_cnt  [2];
        drive_a(1'b1, 1'b1, 2'b11, 4'd6, 8'h11);
        step();
        drive_a(1'b1, 1'b0, 2'b00, 4'd6, 8'h00);
        drive_b(1'b1, 1'b1, 2'b11, 4'd6, 8'h22);
        step();
        got_coll = act_coll;
        got_cnt  = act_cnt;
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (got_coll[d] !== 1'b1 || got_cnt[d] !== 16'd2) begin
                n_fail++; $display("FAIL rw_coll d%0d got coll=%0b cnt=%0d exp coll=1 cnt=2", d, got_coll[d], got_cnt[d]);
            end
            n_checks++;
            if (act_vld[d][0] !== 1'b1 || act_dout[d][0] !== 8'h11) begin
                n_fail++; $display("FAIL rw_read_old d%0d got vld=%0b dout=%h exp vld=1 dout=11", d, act_vld[d][0], act_dout[d][0]);
            end
        end
        n_checks++;
        if (act_vld[1][1] !== 1'b1 || act_dout[1][1] !== 8'h22) begin
            n_fail++; $display("FAIL rw_thru got vld=%0b dout=%h exp vld=1 dout=22", act_vld[1][1], act_dout[1][1]);
        end
        n_checks++;
        if (act_vld[0][1] !== 1'b0) begin n_fail++; $display("FAIL rw_nochg got vld=%0b exp 0", act_vld[0][1]); end
        drive_a(1'b1, 1'b0, 2'b00, 4'd6, 8'h00);
        step();
        idle();
        wait_lat();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_dout[d][0] !== 8'h22) begin n_fail++; $display("FAIL rw_mem d%0d got %h exp 22", d, act_dout[d][0]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            step();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (act_coll[d] !== m_coll || act_cnt[d] !== m_cnt) begin
                    n_fail++; $display("FAIL rand_coll d%0d c%0d got %0b/%0d exp %0b/%0d", d, c, act_coll[d], act_cnt[d], m_coll, m_cnt);
                end
                for (int p = 0; p < 2; p++) begin
                    n_checks++;
                    if (act_vld[d][p] !== e_vld(d, p)) begin
                        n_fail++; $display("FAIL rand_vld d%0d p%0d c%0d got %0b exp %0b", d, p, c, act_vld[d][p], e_vld(d, p));
                    end
                    n_checks++;
                    if (act_dout[d][p] !== e_dout(d, p)) begin
                        n_fail++; $display("FAIL rand_dout d%0d p%0d c%0d got %h exp %h", d, p, c, act_dout[d][p], e_dout(d, p));
                    end
                end
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        drive_a(1'b1, 1'b1, 2'b11, 4'd0, 8'h01);
        drive_b(1'b1, 1'b1, 2'b11, 4'd0, 8'h02);
        for (int i = 0; i < 65536; i++) step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_coll[d] !== 1'b1 || act_cnt[d] !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat_cnt d%0d got coll=%0b cnt=%h exp coll=1 cnt=ffff", d, act_coll[d], act_cnt[d]);
            end
        end
        n_checks++;
        if (m_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_model got %h exp ffff", m_cnt); end
        idle();
        step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (act_coll[d] !== 1'b0 || act_cnt[d] !== 16'hFFFF) begin
                n_fail++; $display("FAIL sat_hold d%0d got coll=%0b cnt=%h exp coll=0 cnt=ffff", d, act_coll[d], act_cnt[d]);
            end
        end
    endtask

    // ---------------------------------------------------------------
    // Sequence and report
    // ---------------------------------------------------------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_busy   = 1'b1;
        m_sweep  = 0;
        m_coll   = 1'b0;
        m_cnt    = 16'h0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_init_readback();
        test_reset_mid_sweep();
        test_lane_mask();
        test_write_write_coll();
        test_read_write_coll();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_true_dp_sc_init.md
Name: ram_true_dp_sc_init

Overview:
Parametrised single-clock true dual-port RAM; successor to the fixed 32768x4 dual-clock dual-port block. Generalised width and depth; adds per-lane write enables, a selectable read-during-write mode, and deterministic cross-port collision resolution with a collision counter. A post-reset init sweep fills every word with a known value. Used as a shared scratch buffer between two engines in the same clock domain.

Parameters:
DATA_W, 4, word width in bits; must be a multiple of LANE_W.
ADDR_W, 15, address width; DEPTH = 2**ADDR_W words.
LANE_W, 4, write-enable lane granularity in bits; NUM_LANES = DATA_W/LANE_W.
RDW_MODE, 0, same-port write behaviour: 0 = no-change (dout holds), 1 = write-through (dout shows merged new word).
INIT_VAL, 0, DATA_W-bit value written to every word during the init sweep.

Ports:
clk  in  1  single clock for both ports, rising edge.
rst_n  in  1  synchronous active-low reset.
init_busy  out  1  high during reset and the init sweep; ports are ignored while high.
en_a  in  1  port A access request.
we_a  in  1  port A write (1) / read (0); qualified by en_a.
be_a  in  NUM_LANES  port A lane write enables; ignored on reads.
addr_a  in  ADDR_W  port A address.
din_a  in  DATA_W  port A write data.
dout_a  out  DATA_W  port A registered read data.
vld_a  out  1  one-cycle pulse marking new dout_a.
en_b, we_b, be_b, addr_b, din_b, dout_b, vld_b: same as port A, for port B.
coll  out  1  one-cycle pulse: same-address access on both ports with at least one write.
coll_cnt  out  16  saturating count of coll pulses.

Behaviour:
- Reset (rst_n=0 at a clk edge): dout_a/b=0, vld_a/b=0, coll=0, coll_cnt=0, init_busy=1, FSM to INIT, sweep pointer=0. Memory contents are not reset directly.
- FSM INIT: each cycle writes INIT_VAL to mem[ptr], then ptr++. After the write to DEPTH-1, go to READY and set init_busy=0 on the next edge. The sweep takes exactly DEPTH cycles after reset release.
- While in INIT, en_a and en_b are ignored: no writes, vld stays 0, coll stays 0.
- Asserting reset mid-sweep restarts the sweep from address 0.
- READY, read (en & !we): dout = mem[addr] on the next edge; vld pulses for 1 cycle (latency 1).
- READY, write (en & we): each lane i with be[i]=1 is written from din; lanes with be[i]=0 keep their old value.
  - RDW_MODE=0: dout holds its previous value and vld=0.
  - RDW_MODE=1: dout = merged new word and vld=1.
- en=0: dout holds and vld=0.
- Cross-port, same address, both writing: per lane, port A wins where be_a=1; port B's lane is used only where be_a=0 and be_b=1.
- Cross-port, same address, one read and one write: the reader gets the OLD word (read-first). The writer behaves per RDW_MODE.
- Cross-port, same address, both reading: no collision; both ports get the same data.
- coll: registered, asserted the cycle after a qualifying collision. coll_cnt increments with it and saturates at 16'hFFFF (no wrap).
- Different addresses on the two ports never interact.

Optional Feature:
RAM_OUT_REG_EN
- Defined: adds one extra output register stage per port. Read latency becomes 2; vld is delayed to stay aligned with dout. The extra stage is reset to 0. coll timing is unchanged.
- Undefined: latency 1 as described above.

Test Plan:
- Init sweep: DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5; release reset -> init_busy high exactly 16 cycles; then reading addr 0..15 returns 8'hA5 with vld one cycle after each en.
- Reset mid-sweep: reset at sweep cycle 7, release -> init_busy high a further full 16 cycles; a port A write issued during the sweep leaves the target word at INIT_VAL.
- Lane mask: DATA_W=8, LANE_W=4. Write A addr 3 din 8'h12 be 2'b11, then din 8'hFF be 2'b01 -> read returns 8'h1F.
- Write-write collision: A writes 8'hAA be 2'b10, B writes 8'h55 be 2'b11, same addr 5 -> mem[5]=8'hA5; coll=1 next cycle; coll_cnt=1.
- Read-write collision: mem[6]=8'h11; A reads, B writes 8'h22 to addr 6 same cycle -> dout_a=8'h11; a later read returns 8'h22. Check RDW_MODE=1 -> dout_b=8'h22 with vld_b=1.
- Saturation and latency: force 65536 collisions -> coll_cnt stays 16'hFFFF. Rerun the read test with RAM_OUT_REG_EN -> vld and dout arrive 2 cycles after en.
